// File: rtl/dmem_responder_2port.sv
// Two-port data-memory responder: round-robin arbitration between two L1 caches,
// fixed-latency word access, one transaction in flight, one-cycle ack per transaction.
module dmem_responder_2port #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_dmem_rd_en,
  input  logic              c0_dmem_wr_en,
  input  logic [ADDR_W-1:0] c0_dmem_address,
  input  logic [DATA_W-1:0] c0_data_to_dmem,
  output logic [DATA_W-1:0] c0_data_from_dmem,
  output logic              c0_dmem_ack,
  input  logic              c1_dmem_rd_en,
  input  logic              c1_dmem_wr_en,
  input  logic [ADDR_W-1:0] c1_dmem_address,
  input  logic [DATA_W-1:0] c1_data_to_dmem,
  output logic [DATA_W-1:0] c1_data_from_dmem,
  output logic              c1_dmem_ack,
  output logic              dmem_busy
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              gnt_port;
  logic              gnt_wr;
  logic              last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_reg;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              req0, req1, grant, pick, done;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req0  = c0_dmem_rd_en | c0_dmem_wr_en;
  assign req1  = c1_dmem_rd_en | c1_dmem_wr_en;
  assign grant = (state == IDLE) && (req0 || req1);
  // On a tie the port that did not win last time goes first.
  assign pick  = (req0 && req1) ? ~last_grant : req1;
  assign done  = (state == BUSY) && (cnt == '0);

  // A port raising rd_en and wr_en together is served as a write.
  assign sel_wr    = pick ? c1_dmem_wr_en   : c0_dmem_wr_en;
  assign sel_addr  = pick ? c1_dmem_address : c0_dmem_address;
  assign sel_wdata = pick ? c1_data_to_dmem : c0_data_to_dmem;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = BUSY;
      BUSY:    if (done)  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      gnt_port   <= 1'b0;
      gnt_wr     <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_reg  <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        gnt_port   <= pick;
        gnt_wr     <= sel_wr;
        addr_q     <= sel_addr;
        wdata_q    <= sel_wdata;
        cnt        <= CNT_W'(LATENCY - 1);
        last_grant <= pick;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (done && !gnt_wr) rdata_reg <= mem[addr_q];
    end
  end

  // Array is not reset; a reset before the commit edge leaves state IDLE so the write is lost.
  always_ff @(posedge clk) begin
    if (done && gnt_wr) mem[addr_q] <= wdata_q;
  end

  assign c0_dmem_ack       = (state == RESP) && !gnt_port;
  assign c1_dmem_ack       = (state == RESP) &&  gnt_port;
  assign c0_data_from_dmem = (c0_dmem_ack && !gnt_wr) ? rdata_reg : '0;
  assign c1_data_from_dmem = (c1_dmem_ack && !gnt_wr) ? rdata_reg : '0;
  assign dmem_busy         = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder_2port.sv
// Scoreboard bench for dmem_responder_2port: expected acks are queued at request time
// and compared (port, data, cycle offset) as the DUT acknowledges.
module tb_dmem_responder_2port;

  logic        clk = 1'b0;
  logic        reset;
  logic        c0_rd, c0_wr, c1_rd, c1_wr;
  logic [9:0]  c0_addr, c1_addr;
  logic [31:0] c0_wdat, c1_wdat;
  logic [31:0] c0_rdat, c1_rdat;
  logic        c0_ack, c1_ack, busy;

  dmem_responder_2port #(.ADDR_W(10), .DATA_W(32), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .c0_dmem_rd_en(c0_rd), .c0_dmem_wr_en(c0_wr), .c0_dmem_address(c0_addr),
    .c0_data_to_dmem(c0_wdat), .c0_data_from_dmem(c0_rdat), .c0_dmem_ack(c0_ack),
    .c1_dmem_rd_en(c1_rd), .c1_dmem_wr_en(c1_wr), .c1_dmem_address(c1_addr),
    .c1_data_to_dmem(c1_wdat), .c1_data_from_dmem(c1_rdat), .c1_dmem_ack(c1_ack),
    .dmem_busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int port; logic [31:0] data; int lat;} exp_t;
  exp_t        q[$];
  exp_t        e;
  logic [31:0] model [int];
  int          checks = 0;
  int          errors = 0;

  task automatic set_req(input int p, input bit rd, input bit wr, input logic [9:0] a, input logic [31:0] d);
    if (p == 0) begin c0_rd = rd; c0_wr = wr; c0_addr = a; c0_wdat = d; end
    else        begin c1_rd = rd; c1_wr = wr; c1_addr = a; c1_wdat = d; end
  endtask

  // Expected result of a transaction, in grant order; writes update the model first.
  task automatic push_exp(input int p, input bit wr, input logic [9:0] a, input logic [31:0] d, input int lat);
    exp_t x;
    x.port = p; x.lat = lat;
    if (wr) begin model[int'(a)] = d; x.data = 32'h0; end
    else x.data = model.exists(int'(a)) ? model[int'(a)] : 32'h0;
    q.push_back(x);
  endtask

  task automatic wait_ack(input int budget, output bit got, output int gp, output logic [31:0] gd, output int at);
    got = 0; gp = -1; gd = 'x; at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (c0_ack || c1_ack) begin
        got = 1; gp = c1_ack ? 1 : 0; gd = c1_ack ? c1_rdat : c0_rdat; at = cyc;
        return;
      end
    end
  endtask

  // Single request, held until ack; returns in the IDLE cycle after RESP.
  task automatic xact(input int p, input bit rd, input bit wr, input logic [9:0] a, input logic [31:0] d,
                      output bit got, output int gp, output logic [31:0] gd, output int lat);
    int start, at;
    set_req(p, rd, wr, a, d);
    start = cyc;
    push_exp(p, wr, a, d, 3);
    wait_ack(20, got, gp, gd, at);
    set_req(p, 0, 0, '0, '0);
    lat = at - start;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    #1;
    checks++;
    if ({busy, c0_ack, c1_ack, c0_rdat, c1_rdat} !== 67'h0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b acks=%b%b d0=%h d1=%h want all 0", busy, c0_ack, c1_ack, c0_rdat, c1_rdat);
    end
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy=%b want 0", busy); end
  endtask

  task automatic test_write_read();
    bit got; int gp, lat; logic [31:0] gd;
    xact(0, 0, 1, 10'h005, 32'hDEADBEEF, got, gp, gd, lat);
    e = q.pop_front();
    checks++;
    if (!got || gp !== e.port || gd !== e.data || lat !== e.lat) begin
      errors++; $display("FAIL wr_005 got=%0d port=%0d data=%h lat=%0d want port=%0d data=%h lat=%0d", got, gp, gd, lat, e.port, e.data, e.lat);
    end
    xact(0, 1, 0, 10'h005, 32'h0, got, gp, gd, lat);
    e = q.pop_front();
    checks++;
    if (!got || gp !== e.port || gd !== e.data || lat !== e.lat) begin
      errors++; $display("FAIL rd_005 got=%0d port=%0d data=%h lat=%0d want port=%0d data=%h lat=%0d", got, gp, gd, lat, e.port, e.data, e.lat);
    end
  endtask

  task automatic test_arb_tie();
    bit got; int gp, lat, start, t; logic [31:0] gd;
    xact(0, 0, 1, 10'h001, 32'h01010101, got, gp, gd, lat); void'(q.pop_front());
    checks++; if (!got) begin errors++; $display("FAIL tie_prefill0 no ack want ack"); end
    xact(1, 0, 1, 10'h002, 32'h02020202, got, gp, gd, lat); void'(q.pop_front());
    checks++; if (!got) begin errors++; $display("FAIL tie_prefill1 no ack want ack"); end
    do_reset();
    set_req(0, 1, 0, 10'h001, '0);
    set_req(1, 1, 0, 10'h002, '0);
    start = cyc;
    push_exp(0, 0, 10'h001, '0, 3);
    push_exp(1, 0, 10'h002, '0, 7);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      t = cyc - start;
      checks++;
      if (busy !== ((t >= 1 && t <= 3) || (t >= 5 && t <= 7))) begin
        errors++; $display("FAIL tie_busy t=%0d busy=%b want %b", t, busy, (t >= 1 && t <= 3) || (t >= 5 && t <= 7));
      end
      if (c0_ack || c1_ack) begin
        gp = c1_ack ? 1 : 0;
        gd = c1_ack ? c1_rdat : c0_rdat;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL tie_extra_ack port=%0d t=%0d want none", gp, t);
        end else begin
          e = q.pop_front();
          if (gp !== e.port || gd !== e.data || t !== e.lat || (c0_ack && c1_ack)) begin
            errors++; $display("FAIL tie_ack port=%0d data=%h t=%0d want port=%0d data=%h t=%0d", gp, gd, t, e.port, e.data, e.lat);
          end
        end
        checks++;
        if ((gp == 0 ? c1_rdat : c0_rdat) !== 32'h0) begin
          errors++; $display("FAIL tie_idle_port_data port=%0d data=%h want 0", 1 - gp, gp == 0 ? c1_rdat : c0_rdat);
        end
        set_req(gp, 0, 0, '0, '0);
      end
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL tie_missing_acks left=%0d want 0", q.size()); q.delete(); end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    bit got; int gp, lat, start, at; logic [31:0] gd;
    xact(0, 0, 1, 10'h100, 32'hAAAA0000, got, gp, gd, lat); void'(q.pop_front());
    checks++; if (!got) begin errors++; $display("FAIL rr_prefill0 no ack want ack"); end
    xact(1, 0, 1, 10'h101, 32'hBBBB1111, got, gp, gd, lat); void'(q.pop_front());
    checks++; if (!got) begin errors++; $display("FAIL rr_prefill1 no ack want ack"); end
    do_reset();
    set_req(0, 1, 0, 10'h100, '0);
    set_req(1, 1, 0, 10'h101, '0);
    start = cyc;
    for (int i = 0; i < 8; i++) push_exp(i % 2, 0, (i % 2) ? 10'h101 : 10'h100, '0, 3 + 4 * i);
    for (int i = 0; i < 8; i++) begin
      wait_ack(10, got, gp, gd, at);
      e = q.pop_front();
      checks++;
      if (!got || gp !== e.port || gd !== e.data || (at - start) !== e.lat) begin
        errors++; $display("FAIL rr_ack%0d got=%0d port=%0d data=%h t=%0d want port=%0d data=%h t=%0d",
                           i, got, gp, gd, at - start, e.port, e.data, e.lat);
      end
      if (!got) break;
    end
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_rd_wr_same_port();
    bit got; int gp, lat, at; logic [31:0] gd;
    xact(1, 1, 1, 10'h3FF, 32'h00001234, got, gp, gd, lat);
    e = q.pop_front();
    checks++;
    if (!got || gp !== e.port || gd !== e.data || lat !== e.lat) begin
      errors++; $display("FAIL rdwr_ack got=%0d port=%0d data=%h lat=%0d want port=%0d data=%h lat=%0d", got, gp, gd, lat, e.port, e.data, e.lat);
    end
    wait_ack(6, got, gp, gd, at);
    checks++;
    if (got) begin errors++; $display("FAIL rdwr_second_ack port=%0d want none", gp); end
    @(posedge clk); #1;
    xact(0, 1, 0, 10'h3FF, '0, got, gp, gd, lat);
    e = q.pop_front();
    checks++;
    if (!got || gd !== e.data) begin
      errors++; $display("FAIL rd_3ff got=%0d data=%h want %h", got, gd, e.data);
    end
  endtask

  task automatic test_reset_abort();
    bit got; int gp, lat, at; logic [31:0] gd;
    xact(0, 0, 1, 10'h010, 32'h11112222, got, gp, gd, lat); void'(q.pop_front());
    checks++; if (!got) begin errors++; $display("FAIL abort_prefill no ack want ack"); end
    set_req(0, 0, 1, 10'h010, 32'hA5A5A5A5);
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_in_busy busy=%b want 1", busy); end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, c0_ack, c1_ack, c0_rdat, c1_rdat} !== 67'h0) begin
      errors++; $display("FAIL abort_outputs busy=%b acks=%b%b d0=%h d1=%h want all 0", busy, c0_ack, c1_ack, c0_rdat, c1_rdat);
    end
    set_req(0, 0, 0, '0, '0);
    #2 reset = 1'b0;
    wait_ack(8, got, gp, gd, at);
    checks++;
    if (got) begin errors++; $display("FAIL abort_ack port=%0d want none", gp); end
    @(posedge clk); #1;
    xact(0, 1, 0, 10'h010, '0, got, gp, gd, lat);
    e = q.pop_front();
    checks++;
    if (!got || gd !== e.data) begin
      errors++; $display("FAIL abort_readback got=%0d data=%h want %h", got, gd, e.data);
    end
  endtask

  task automatic test_ordering();
    bit got; int gp, lat, start, at; logic [31:0] gd;
    // A lone core0 access leaves last_grant at 0 so core1 wins the tie below.
    xact(0, 0, 1, 10'h000, 32'h0, got, gp, gd, lat); void'(q.pop_front());
    checks++; if (!got) begin errors++; $display("FAIL ord_prefill no ack want ack"); end
    set_req(1, 0, 1, 10'h000, 32'hCAFEF00D);
    set_req(0, 1, 0, 10'h000, '0);
    start = cyc;
    push_exp(1, 1, 10'h000, 32'hCAFEF00D, 3);
    push_exp(0, 0, 10'h000, '0, 7);
    for (int i = 0; i < 2; i++) begin
      wait_ack(10, got, gp, gd, at);
      e = q.pop_front();
      checks++;
      if (!got || gp !== e.port || gd !== e.data || (at - start) !== e.lat) begin
        errors++; $display("FAIL ord_ack%0d got=%0d port=%0d data=%h t=%0d want port=%0d data=%h t=%0d",
                           i, got, gp, gd, at - start, e.port, e.data, e.lat);
      end
      if (got) set_req(gp, 0, 0, '0, '0);
    end
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0;
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_arb_tie();
    test_round_robin();
    test_rd_wr_same_port();
    test_reset_abort();
    test_ordering();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
